spi_tx_stream: RTL and testbench

SPI_TX_STREAM -- requirements
Module: spi_tx_stream

---
 rtl/spi_tx_stream.sv | 197 +++++++++++++++++++
 tb/tb_spi_tx_stream.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_stream.sv
// SPI slave transmitter fed from an AXI-stream FIFO. spi_clk/spi_cs are oversampled
// on axi_aclk; each word is popped in LOAD and shifted out on spi_miso in SHIFT.
module spi_tx_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int MSB_FIRST = 1,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL = '0
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic                          spi_clk,
  input  logic                          spi_cs,
  output logic                          spi_miso,
  output logic                          spi_miso_oe,
  input  logic                          axis_rvalid,
  output logic                          axis_rready,
  input  logic [DATA_WIDTH-1:0]         axis_rdata,
  input  logic                          axis_rlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          frame_done
);

  // state  | meaning
  // IDLE   | chip select high, miso held 0, spi_clk edges ignored
  // LOAD   | one cycle: pop FIFO head (or IDLE_FILL) into the shift register
  // SHIFT  | sample edges count bits, shift edges present the next bit

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [PW:0] LVL_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic CLK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  state_t                state_q, state_d;
  logic                  sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_d1_q, sclk_d1_d;
  logic                  cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_d1_q, cs_d1_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic                  underrun_q, underrun_d;
  logic                  frame_done_q, frame_done_d;
  logic                  rready_q, rready_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           level_q, level_d;
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, wr_en, rd_en;
  logic [DATA_WIDTH:0] head;

  assign sclk_rise   = sclk_s2_q & ~sclk_d1_q;
  assign sclk_fall   = ~sclk_s2_q & sclk_d1_q;
  assign lead_edge   = CLK_IDLE ? sclk_fall : sclk_rise;
  assign trail_edge  = CLK_IDLE ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s2_q & cs_d1_q;
  assign cs_rise     = cs_s2_q & ~cs_d1_q;
  assign head        = mem_q[rd_ptr_q];
  assign wr_en       = axis_rvalid & rready_q;

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
  endfunction

  always_comb begin
    sclk_s1_d    = spi_clk;
    sclk_s2_d    = sclk_s1_q;
    sclk_d1_d    = sclk_s2_q;
    cs_s1_d      = spi_cs;
    cs_s2_d      = cs_s1_q;
    cs_d1_d      = cs_s2_q;
    state_d      = state_q;
    sh_d         = sh_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    miso_d       = miso_q;
    oe_d         = ~cs_s2_q;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;
    rd_en        = 1'b0;

    if (cs_rise) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (cs_fall) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          if (level_q != '0) begin
            rd_en  = 1'b1;
            sh_d   = head[DATA_WIDTH-1:0];
            last_d = head[DATA_WIDTH];
          end else begin
            sh_d       = IDLE_FILL;
            last_d     = 1'b0;
            underrun_d = 1'b1;
          end
          cnt_d   = '0;
          miso_d  = out_bit(sh_d);
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          // a shift edge before the word's first sample belongs to the previous word
          if (sample_edge) begin
            if (cnt_q == CNT_LAST) begin
              state_d      = ST_LOAD;
              cnt_d        = '0;
              frame_done_d = last_q;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (shift_edge && cnt_q != '0) begin
            sh_d   = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
            miso_d = out_bit(sh_d);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (PW + 1)'(1);
      2'b01:   level_d = level_q - (PW + 1)'(1);
      default: level_d = level_q;
    endcase
    rready_d = (level_d != LVL_FULL);
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      sclk_s1_q    <= CLK_IDLE;
      sclk_s2_q    <= CLK_IDLE;
      sclk_d1_q    <= CLK_IDLE;
      cs_s1_q      <= 1'b1;
      cs_s2_q      <= 1'b1;
      cs_d1_q      <= 1'b1;
      state_q      <= ST_IDLE;
      sh_q         <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
      rready_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      sclk_s1_q    <= sclk_s1_d;
      sclk_s2_q    <= sclk_s2_d;
      sclk_d1_q    <= sclk_d1_d;
      cs_s1_q      <= cs_s1_d;
      cs_s2_q      <= cs_s2_d;
      cs_d1_q      <= cs_d1_d;
      state_q      <= state_d;
      sh_q         <= sh_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
      rready_q     <= rready_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  // storage needs no reset; the pointers alone define valid entries
  always_ff @(posedge axi_aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {axis_rlast, axis_rdata};
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign axis_rready = rready_q;
  assign fifo_level  = level_q;
  assign underrun    = underrun_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_spi_tx_stream.sv
// Bench for spi_tx_stream: instance 0 runs SPI mode 0 with IDLE_FILL=FF, instance 1 mode 3
// with IDLE_FILL=00; a queue model predicts every shifted word and pulse count.
module tb_spi_tx_stream;
  localparam int HALF = 8;

  logic       axi_aclk = 1'b0;
  logic       axi_areset = 1'b1;
  logic [1:0] spi_clk = 2'b10;
  logic [1:0] spi_cs = 2'b11;
  logic [1:0] axis_rvalid = 2'b00;
  logic [1:0] axis_rlast = 2'b00;
  logic [7:0] axis_rdata [2];
  wire  [1:0] spi_miso, spi_miso_oe, axis_rready, underrun, frame_done;
  wire  [4:0] fifo_level [2];

  int n_checks = 0;
  int n_errors = 0;
  int un_cnt [2] = '{0, 0};
  int fd_cnt [2] = '{0, 0};
  int exp_un [2] = '{0, 0};
  int exp_fd [2] = '{0, 0};
  logic [8:0] mq0 [$];
  logic [8:0] mq1 [$];
  logic [8:0] cur [2];

  always #5 axi_aclk = ~axi_aclk;

  spi_tx_stream #(.CPOL(0), .CPHA(0), .IDLE_FILL(8'hFF)) u_m0 (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset), .spi_clk(spi_clk[0]), .spi_cs(spi_cs[0]),
    .spi_miso(spi_miso[0]), .spi_miso_oe(spi_miso_oe[0]), .axis_rvalid(axis_rvalid[0]),
    .axis_rready(axis_rready[0]), .axis_rdata(axis_rdata[0]), .axis_rlast(axis_rlast[0]),
    .fifo_level(fifo_level[0]), .underrun(underrun[0]), .frame_done(frame_done[0]));

  spi_tx_stream #(.CPOL(1), .CPHA(1), .IDLE_FILL(8'h00)) u_m3 (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset), .spi_clk(spi_clk[1]), .spi_cs(spi_cs[1]),
    .spi_miso(spi_miso[1]), .spi_miso_oe(spi_miso_oe[1]), .axis_rvalid(axis_rvalid[1]),
    .axis_rready(axis_rready[1]), .axis_rdata(axis_rdata[1]), .axis_rlast(axis_rlast[1]),
    .fifo_level(fifo_level[1]), .underrun(underrun[1]), .frame_done(frame_done[1]));

  always @(posedge axi_aclk) begin
    if (underrun[0] === 1'b1)   un_cnt[0] <= un_cnt[0] + 1;
    if (underrun[1] === 1'b1)   un_cnt[1] <= un_cnt[1] + 1;
    if (frame_done[0] === 1'b1) fd_cnt[0] <= fd_cnt[0] + 1;
    if (frame_done[1] === 1'b1) fd_cnt[1] <= fd_cnt[1] + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge axi_aclk);
  endtask

  function automatic int model_size(input int m);
    return (m == 0) ? mq0.size() : mq1.size();
  endfunction

  // Every LOAD takes the queue head, or the instance's fill word with an underrun.
  task automatic model_load(input int m);
    if (m == 0) begin
      if (mq0.size() > 0) cur[0] = mq0.pop_front();
      else begin cur[0] = {1'b0, 8'hFF}; exp_un[0]++; end
    end else begin
      if (mq1.size() > 0) cur[1] = mq1.pop_front();
      else begin cur[1] = {1'b0, 8'h00}; exp_un[1]++; end
    end
  endtask

  task automatic push(input int m, input logic [7:0] d, input logic l);
    int budget = 0;
    @(negedge axi_aclk);
    axis_rvalid[m] = 1'b1;
    axis_rdata[m]  = d;
    axis_rlast[m]  = l;
    while (axis_rready[m] !== 1'b1 && budget < 200) begin
      @(negedge axi_aclk);
      budget++;
    end
    n_checks++;
    if (axis_rready[m] !== 1'b1) begin
      n_errors++;
      $display("FAIL push_ready m%0d: rready=%b required 1 within 200 cycles", m, axis_rready[m]);
    end else begin
      @(negedge axi_aclk);
      if (m == 0) mq0.push_back({l, d}); else mq1.push_back({l, d});
    end
    axis_rvalid[m] = 1'b0;
  endtask

  task automatic spi_begin(input int m);
    @(negedge axi_aclk);
    spi_cs[m] = 1'b0;
    wait_cyc(HALF);
    model_load(m);
  endtask

  task automatic spi_end(input int m);
    spi_cs[m] = 1'b1;
    wait_cyc(HALF);
  endtask

  // Instance m uses CPOL=CPHA=m; the master samples miso just before its sample edge.
  task automatic spi_bit(input int m, output logic b);
    if (m == 0) begin
      b = spi_miso[0];
      spi_clk[0] = 1'b1;
      wait_cyc(HALF);
      spi_clk[0] = 1'b0;
      wait_cyc(HALF);
    end else begin
      spi_clk[1] = 1'b0;
      wait_cyc(HALF);
      b = spi_miso[1];
      spi_clk[1] = 1'b1;
      wait_cyc(HALF);
    end
  endtask

  task automatic xfer_word(input int m, output logic [7:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      spi_bit(m, b);
      w = {w[6:0], b};
    end
  endtask

  task automatic check_word(input int m, input string name);
    logic [7:0] w;
    logic [8:0] e;
    e = cur[m];
    xfer_word(m, w);
    n_checks++;
    if (w !== e[7:0]) begin
      n_errors++;
      $display("FAIL %s m%0d: miso word=%02h required %02h", name, m, w, e[7:0]);
    end
    if (e[8]) exp_fd[m]++;
    model_load(m);
  endtask

  task automatic check_counts(input int m, input string name);
    n_checks++;
    if (un_cnt[m] !== exp_un[m]) begin
      n_errors++;
      $display("FAIL %s_underrun m%0d: pulses=%0d required %0d", name, m, un_cnt[m], exp_un[m]);
    end
    n_checks++;
    if (fd_cnt[m] !== exp_fd[m]) begin
      n_errors++;
      $display("FAIL %s_frame_done m%0d: pulses=%0d required %0d", name, m, fd_cnt[m], exp_fd[m]);
    end
    n_checks++;
    if (fifo_level[m] !== 5'(model_size(m))) begin
      n_errors++;
      $display("FAIL %s_level m%0d: level=%0d required %0d", name, m, fifo_level[m], model_size(m));
    end
  endtask

  task automatic check_idle_outputs(input int m, input string name);
    n_checks++;
    if ({axis_rready[m], spi_miso[m], spi_miso_oe[m], underrun[m], frame_done[m]} !== 5'b0 ||
        fifo_level[m] !== 5'd0) begin
      n_errors++;
      $display("FAIL %s m%0d: rdy/miso/oe/un/fd=%b%b%b%b%b level=%0d required 00000 level=0", name, m,
               axis_rready[m], spi_miso[m], spi_miso_oe[m], underrun[m], frame_done[m], fifo_level[m]);
    end
  endtask

  task automatic test_reset();
    axi_areset = 1'b1;
    wait_cyc(5);
    check_idle_outputs(0, "reset_outputs");
    check_idle_outputs(1, "reset_outputs");
    axi_areset = 1'b0;
    @(negedge axi_aclk);
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (axis_rready[m] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_release_rready m%0d: rready=%b required 1", m, axis_rready[m]);
      end
    end
  endtask

  task automatic test_mode0();
    push(0, 8'h5A, 1'b1);
    spi_begin(0);
    check_word(0, "mode0_5a");
    spi_end(0);
    check_counts(0, "mode0");
  endtask

  task automatic test_mode3();
    push(1, 8'hA5, 1'b0);
    push(1, 8'h3C, 1'b0);
    spi_begin(1);
    check_word(1, "mode3_w0");
    check_word(1, "mode3_w1");
    spi_end(1);
    check_counts(1, "mode3");
  endtask

  task automatic test_underrun();
    spi_begin(0);
    check_word(0, "underrun_fill");
    spi_end(0);
    check_counts(0, "underrun");
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) push(0, 8'($urandom), 1'($urandom));
    @(negedge axi_aclk);
    n_checks++;
    if (fifo_level[0] !== 5'd16 || axis_rready[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL full_16 m0: level=%0d rready=%b required 16 and 0", fifo_level[0], axis_rready[0]);
    end
    axis_rvalid[0] = 1'b1;
    axis_rdata[0]  = 8'hEE;
    wait_cyc(10);
    n_checks++;
    if (fifo_level[0] !== 5'd16 || axis_rready[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL full_held m0: level=%0d rready=%b required 16 and 0", fifo_level[0], axis_rready[0]);
    end
    axis_rvalid[0] = 1'b0;
    spi_begin(0);
    for (int i = 0; i < 16; i++) check_word(0, "full_drain");
    spi_end(0);
    check_counts(0, "full");
  endtask

  task automatic test_abort();
    logic [7:0] nxt;
    logic [2:0] part;
    logic b;
    nxt = 8'($urandom);
    push(0, 8'hC3, 1'b1);
    push(0, nxt, 1'b1);
    spi_begin(0);
    part = '0;
    for (int i = 0; i < 3; i++) begin
      spi_bit(0, b);
      part = {part[1:0], b};
    end
    n_checks++;
    if (part !== 3'b110 || spi_miso_oe[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_partial m0: bits=%b oe=%b required 110 and 1", part, spi_miso_oe[0]);
    end
    spi_end(0);
    n_checks++;
    if (spi_miso_oe[0] !== 1'b0 || spi_miso[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_oe m0: oe=%b miso=%b required 0 and 0", spi_miso_oe[0], spi_miso[0]);
    end
    check_counts(0, "abort_mid");
    spi_begin(0);
    check_word(0, "abort_next");
    spi_end(0);
    check_counts(0, "abort");
  endtask

  task automatic test_reset_mid();
    logic [7:0] part;
    logic b;
    for (int i = 0; i < 4; i++) push(0, 8'($urandom), 1'b1);
    spi_begin(0);
    part = '0;
    for (int i = 0; i < 4; i++) begin
      spi_bit(0, b);
      part = {part[6:0], b};
    end
    n_checks++;
    if (part[3:0] !== cur[0][7:4]) begin
      n_errors++;
      $display("FAIL reset_mid_bits m0: bits=%b required %b", part[3:0], cur[0][7:4]);
    end
    wait_cyc(2);
    axi_areset = 1'b1;
    @(negedge axi_aclk);
    check_idle_outputs(0, "reset_mid_outputs");
    spi_cs[0] = 1'b1;
    wait_cyc(3);
    axi_areset = 1'b0;
    mq0.delete();
    mq1.delete();
    wait_cyc(HALF);
    check_counts(0, "reset_mid");
    check_counts(1, "reset_mid");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int m = int'($urandom_range(0, 1));
      int n = int'($urandom_range(1, 5));
      int extra = int'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) push(m, 8'($urandom), 1'($urandom));
      spi_begin(m);
      for (int i = 0; i < n + extra; i++) check_word(m, "random_word");
      spi_end(m);
      check_counts(m, "random");
    end
  endtask

  initial begin
    axis_rdata[0] = '0;
    axis_rdata[1] = '0;
    test_reset();
    test_mode0();
    test_mode3();
    test_underrun();
    test_full();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end
endmodule
